// File: rtl/alu_pkg.sv
// alu_seq shared types: opcodes, FSM states, BCD constants.
// Imported by the interface, the digit adder and the top.
package alu_pkg;

  typedef enum logic [4:0] {
    NOP, LD, ADD, SUB,
    IAC, DAC, CLB, CLC,
    STC, CMC, RAL, RAR,
    TCC, TCS, DAA, KBP,
    MDADD, MDSUB
  } op_t;

  typedef enum logic [1:0] {
    IDLE, EXEC, MD_RUN, MD_LAST
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // one-hot keyboard line to its index, anything else is F
  function automatic logic [3:0] kbp(
    input logic [3:0] n
  );
    unique case (n)
      4'h0:    kbp = 4'h0;
      4'h1:    kbp = 4'h1;
      4'h2:    kbp = 4'h2;
      4'h4:    kbp = 4'h3;
      4'h8:    kbp = 4'h4;
      default: kbp = 4'hf;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq command / completion / digit-stream bundle.
// slave is the ALU side, master the decoder+RAM side.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = 4
) ();

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] opa;
  logic             out_valid;
  logic [WIDTH-1:0] acc_out;
  logic             cy_out;
  logic             zero_out;
  logic             dig_req;
  logic [IW-1:0]    dig_idx;
  logic [3:0]       dig_a;
  logic [3:0]       dig_b;
  logic             dig_valid;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [3:0]       wr_data;

  modport slave (
    input  in_valid, op, opa,
    input  dig_a, dig_b, dig_valid,
    output in_ready, out_valid,
    output acc_out, cy_out, zero_out,
    output dig_req, dig_idx,
    output wr_en, wr_idx, wr_data
  );

  modport master (
    output in_valid, op, opa,
    output dig_a, dig_b, dig_valid,
    input  in_ready, out_valid,
    input  acc_out, cy_out, zero_out,
    input  dig_req, dig_idx,
    input  wr_en, wr_idx, wr_data
  );

endinterface

// File: rtl/alu_seq_bcd_digit_adder.sv
// One BCD digit add with carry; sub mode uses the
// nine's complement of b so CY=1 in means no borrow.
module bcd_digit_adder
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);

  logic [3:0] bx;
  logic [4:0] s;

  always_comb begin
    bx    = sub ? BCD_MAX - b : b;
    s     = {1'b0, a} + {1'b0, bx} + {4'b0, cin};
    cout  = s > {1'b0, BCD_MAX};
    digit = cout ? s[3:0] + 4'd6 : s[3:0];
  end

endmodule

// File: rtl/alu_seq.sv
// Registered accumulator/carry ALU with a streaming
// multi-digit BCD add/subtract engine.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MAXDIG = 16,
  parameter int IW     = $clog2(MAXDIG)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int LW = IW + 1;
  localparam logic [LW-1:0] NMAX = LW'(MAXDIG);

  state_t           state;
  logic [WIDTH-1:0] acc, acc_n;
  logic             cy, cy_n;
  logic [IW-1:0]    idx;
  logic [LW-1:0]    nlen, nreq, nclamp;
  logic             zacc, msub, last;
  logic             out_valid, zero_q;
  logic             dig_req, wr_en;
  logic [IW-1:0]    wr_idx;
  logic [3:0]       wr_data;
  logic [3:0]       md_digit, daa_digit;
  logic             md_cout, daa_cout;
  logic [3:0]       nib;

  bcd_digit_adder u_md (
    .a     (bus.dig_a),
    .b     (bus.dig_b),
    .cin   (cy),
    .sub   (msub),
    .digit (md_digit),
    .cout  (md_cout)
  );

  // nibble > 9 shows up as cout with b=0
  bcd_digit_adder u_daa (
    .a     (acc[3:0]),
    .b     (4'd0),
    .cin   (1'b0),
    .sub   (1'b0),
    .digit (daa_digit),
    .cout  (daa_cout)
  );

  always_comb begin
    nib   = acc[3:0];
    acc_n = acc;
    cy_n  = cy;
    unique case (bus.op)
      LD:  acc_n = bus.opa;
      ADD: {cy_n, acc_n} = {1'b0, acc}
             + {1'b0, bus.opa}
             + {{WIDTH{1'b0}}, cy};
      SUB: {cy_n, acc_n} = {1'b0, acc}
             + {1'b0, ~bus.opa}
             + {{WIDTH{1'b0}}, cy};
      IAC: {cy_n, acc_n} = {1'b0, acc}
             + {{WIDTH{1'b0}}, 1'b1};
      DAC: {cy_n, acc_n} = {1'b0, acc}
             + {1'b0, {WIDTH{1'b1}}};
      CLB: begin
        acc_n = '0;
        cy_n  = 1'b0;
      end
      CLC: cy_n = 1'b0;
      STC: cy_n = 1'b1;
      CMC: cy_n = ~cy;
      RAL: {cy_n, acc_n} = {acc, cy};
      RAR: {acc_n, cy_n} = {cy, acc};
      TCC: begin
        acc_n    = '0;
        acc_n[0] = cy;
        cy_n     = 1'b0;
      end
      TCS: begin
        acc_n      = '0;
        acc_n[3:0] = cy ? 4'd10 : 4'd9;
        cy_n       = 1'b0;
      end
      DAA: begin
        if (daa_cout)
          acc_n[3:0] = daa_digit;
        else if (cy)
          acc_n[3:0] = nib + 4'd6;
        cy_n = cy | daa_cout;
      end
      KBP: begin
        acc_n      = '0;
        acc_n[3:0] = kbp(nib);
      end
      default: ;
    endcase
  end

  always_comb begin
    nreq   = LW'(bus.opa);
    nclamp = (nreq > NMAX) ? NMAX : nreq;
    last   = {1'b0, idx} == nlen - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cy        <= 1'b0;
      idx       <= '0;
      nlen      <= '0;
      zacc      <= 1'b0;
      msub      <= 1'b0;
      out_valid <= 1'b0;
      zero_q    <= 1'b0;
      dig_req   <= 1'b0;
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_data   <= '0;
    end else begin
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      unique case (state)
        IDLE: if (bus.in_valid) begin
          if ((bus.op inside {MDADD, MDSUB})
              && nclamp != '0) begin
            state   <= MD_RUN;
            idx     <= '0;
            nlen    <= nclamp;
            zacc    <= 1'b1;
            msub    <= bus.op == MDSUB;
            dig_req <= 1'b1;
          end else begin
            state     <= EXEC;
            acc       <= acc_n;
            cy        <= cy_n;
            zero_q    <= acc_n == '0;
            out_valid <= 1'b1;
          end
        end
        EXEC: state <= IDLE;
        MD_RUN: if (bus.dig_valid) begin
          wr_en   <= 1'b1;
          wr_idx  <= idx;
          wr_data <= md_digit;
          cy      <= md_cout;
          zacc    <= zacc & (md_digit == 4'd0);
          idx     <= idx + 1'b1;
          // completion lands with the last write
          if (last) begin
            state     <= MD_LAST;
            dig_req   <= 1'b0;
            acc       <= WIDTH'(md_digit);
            zero_q    <= zacc & (md_digit == 4'd0);
            out_valid <= 1'b1;
          end
        end
        MD_LAST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = out_valid;
  assign bus.acc_out   = acc;
  assign bus.cy_out    = cy;
  assign bus.zero_out  = zero_q;
  assign bus.dig_req   = dig_req;
  assign bus.dig_idx   = idx;
  assign bus.wr_en     = wr_en;
  assign bus.wr_idx    = wr_idx;
  assign bus.wr_data   = wr_data;

endmodule
